// File: rtl/cache_axi_bridge.sv
// Cache-line AXI master: turns each refill/writeback line request into one INCR burst.
// Read and write channels run as independent FSMs; a read that hits a line being written back waits.
module cache_axi_bridge #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned WORD_W     = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         rd_req,
    input  logic [31:0]                  rd_addr,
    output logic                         rd_rdy,
    output logic                         ret_valid,
    output logic [LINE_WORDS*WORD_W-1:0] ret_data,
    input  logic                         wr_req,
    input  logic [31:0]                  wr_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] wr_data,
    output logic                         wr_rdy,
    output logic                         wr_valid,
    output logic [31:0]                  araddr,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [WORD_W-1:0]            rdata,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [31:0]                  awaddr,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [WORD_W-1:0]            wdata,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int unsigned CntW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {RdIdle, RdAr, RdData, RdDone} rd_state_e;
    typedef enum logic [2:0] {WrIdle, WrAw, WrData, WrResp, WrDone} wr_state_e;

    rd_state_e         r_rd_state;
    logic [CntW-1:0]   r_rcnt;
    logic [31:0]       r_araddr;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_ret_valid;
    logic [WORD_W-1:0] r_ret_words [LINE_WORDS];

    wr_state_e         r_wr_state;
    logic [CntW-1:0]   r_wcnt;
    logic [31:0]       r_awaddr;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_wr_valid;
    logic [WORD_W-1:0] r_wbuf [LINE_WORDS];

    logic w_rd_fire;
    logic w_wr_fire;
    logic w_raw_hit;
    logic w_unused_addr;

    // Line offset bits are don't-care: every burst starts on a line boundary.
    assign w_unused_addr = ^{rd_addr[3:0], wr_addr[3:0]};

    assign wr_rdy    = resetn && (r_wr_state == WrIdle);
    assign w_wr_fire = wr_req && wr_rdy;

    // Hold off a refill of a line that is still being (or about to be) written back.
    assign w_raw_hit = ((r_wr_state != WrIdle) && (r_awaddr[31:4] == rd_addr[31:4])) ||
                       (w_wr_fire && (wr_addr[31:4] == rd_addr[31:4]));
    assign rd_rdy    = resetn && (r_rd_state == RdIdle) && !w_raw_hit;
    assign w_rd_fire = rd_req && rd_rdy;

    assign araddr    = r_araddr;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign ret_valid = r_ret_valid;

    assign awaddr    = r_awaddr;
    assign awvalid   = r_awvalid;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wbuf[r_wcnt];
    assign wlast     = r_wvalid && (r_wcnt == LastBeat);
    assign bready    = r_bready;
    assign wr_valid  = r_wr_valid;

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_ret
        assign ret_data[g*WORD_W +: WORD_W] = r_ret_words[g];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rd_state  <= RdIdle;
            r_rcnt      <= '0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_ret_valid <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) r_ret_words[i] <= '0;
        end else begin
            r_ret_valid <= 1'b0;
            unique case (r_rd_state)
                RdIdle: begin
                    if (w_rd_fire) begin
                        r_araddr   <= {rd_addr[31:4], 4'h0};
                        r_arvalid  <= 1'b1;
                        r_rd_state <= RdAr;
                    end
                end
                RdAr: begin
                    if (arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_rd_state <= RdData;
                    end
                end
                RdData: begin
                    if (rvalid) begin
                        r_ret_words[r_rcnt] <= rdata;
                        if (rlast) begin
                            r_rcnt      <= '0;
                            r_rready    <= 1'b0;
                            r_ret_valid <= 1'b1;
                            r_rd_state  <= RdDone;
                        end else if (r_rcnt != LastBeat) begin
                            r_rcnt <= r_rcnt + CntW'(1);
                        end
                    end
                end
                RdDone: r_rd_state <= RdIdle;
                default: r_rd_state <= RdIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_state <= WrIdle;
            r_wcnt     <= '0;
            r_awaddr   <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_wr_valid <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) r_wbuf[i] <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            unique case (r_wr_state)
                WrIdle: begin
                    if (w_wr_fire) begin
                        r_awaddr   <= {wr_addr[31:4], 4'h0};
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            r_wbuf[i] <= wr_data[i*WORD_W +: WORD_W];
                        end
                        r_awvalid  <= 1'b1;
                        r_wr_state <= WrAw;
                    end
                end
                WrAw: begin
                    if (awready) begin
                        r_awvalid  <= 1'b0;
                        r_wvalid   <= 1'b1;
                        r_wr_state <= WrData;
                    end
                end
                WrData: begin
                    if (wready) begin
                        if (r_wcnt == LastBeat) begin
                            r_wcnt     <= '0;
                            r_wvalid   <= 1'b0;
                            r_bready   <= 1'b1;
                            r_wr_state <= WrResp;
                        end else begin
                            r_wcnt <= r_wcnt + CntW'(1);
                        end
                    end
                end
                WrResp: begin
                    if (bvalid) begin
                        r_bready   <= 1'b0;
                        r_wr_valid <= 1'b1;
                        r_wr_state <= WrDone;
                    end
                end
                WrDone: r_wr_state <= WrIdle;
                default: r_wr_state <= WrIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Scoreboard bench for cache_axi_bridge: stimulus pushes expected AXI/completion events,
// a monitor pops and compares them as the bridge presents them; a small AXI slave responds.
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [127:0] ret_data;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_rdy;
    logic         wr_valid;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bvalid;
    logic         bready;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ret_cyc = 0;
    int wdone_cyc = 0;

    logic [31:0] rd_base = 32'h0;
    int          rd_beat = 0;
    bit          rd_act = 1'b0;
    int          b_delay = 0;
    bit          w_toggle = 1'b0;

    logic [31:0]  exp_ar[$];
    logic [31:0]  exp_aw[$];
    logic [32:0]  exp_w[$];
    logic [127:0] exp_ret[$];
    int           exp_wdone[$];

    cache_axi_bridge #(
        .LINE_WORDS(4),
        .WORD_W    (32)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_rdy   (rd_rdy),
        .ret_valid(ret_valid),
        .ret_data (ret_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy),
        .wr_valid (wr_valid),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 128'({rd_rdy, wr_rdy, ret_valid, wr_valid, arvalid, rready,
                                 awvalid, wvalid, wlast, bready}), 128'd0);
        chk({tag, "_addr"}, 128'({araddr, awaddr}), 128'd0);
        chk({tag, "_ret_data"}, ret_data, 128'd0);
        chk({tag, "_wdata"}, 128'(wdata), 128'd0);
    endtask

    task automatic push_rd(input logic [31:0] addr, input logic [127:0] line);
        exp_ar.push_back({addr[31:4], 4'h0});
        exp_ret.push_back(line);
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [127:0] data);
        exp_aw.push_back({addr[31:4], 4'h0});
        for (int i = 0; i < 4; i++) exp_w.push_back({i == 3, data[i*32 +: 32]});
        exp_wdone.push_back(1);
    endtask

    task automatic rd_issue(input logic [31:0] addr, input logic [31:0] base,
                            input logic [127:0] line, output int waited, output int acc);
        int n;
        n = 0;
        rd_base = base;
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = addr;
        #1;
        while (!rd_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rd_accept", 128'(rd_rdy), 128'd1);
        if (rd_rdy) push_rd(addr, line);
        waited = n;
        acc = cyc;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wr_issue(input logic [31:0] addr, input logic [127:0] data);
        int n;
        n = 0;
        @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        #1;
        while (!wr_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wr_accept", 128'(wr_rdy), 128'd1);
        if (wr_rdy) push_wr(addr, data);
        @(negedge clk);
        wr_req  = 1'b0;
        wr_data = ~data;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_ar.size() + exp_aw.size() + exp_w.size() + exp_ret.size() +
                exp_wdone.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_ret.size() +
                      exp_wdone.size()), 128'd0);
        repeat (2) @(negedge clk);
    endtask

    // AXI read slave: arready always high, one INCR burst of rd_base+beat words per AR.
    initial begin : rslave
        bit ar_hs;
        bit r_hs;
        ar_hs = 1'b0;
        r_hs = 1'b0;
        arready = 1'b1;
        rvalid = 1'b0;
        rlast = 1'b0;
        rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                ar_hs = 1'b0;
                r_hs = 1'b0;
                rd_act = 1'b0;
                rd_beat = 0;
                rvalid = 1'b0;
                rlast = 1'b0;
                rdata = 32'h0;
            end else begin
                if (r_hs) begin
                    rd_beat++;
                    if (rd_beat == 4) begin
                        rd_act = 1'b0;
                        rd_beat = 0;
                    end
                end
                if (ar_hs) begin
                    rd_act = 1'b1;
                    rd_beat = 0;
                end
                rvalid = rd_act;
                rdata = rd_act ? rd_base + 32'(rd_beat) : 32'h0;
                rlast = rd_act && (rd_beat == 3);
                #1;
                ar_hs = arvalid && arready;
                r_hs = rvalid && rready;
            end
        end
    end

    // AXI write slave: awready high, wready optionally toggling, B after b_delay cycles.
    initial begin : wslave
        bit wl_hs;
        bit b_hs;
        int bcnt;
        wl_hs = 1'b0;
        b_hs = 1'b0;
        bcnt = -1;
        awready = 1'b1;
        wready = 1'b1;
        bvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                wl_hs = 1'b0;
                b_hs = 1'b0;
                bcnt = -1;
                wready = 1'b1;
                bvalid = 1'b0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (wl_hs) bcnt = b_delay;
                if (bcnt == 0) begin
                    bvalid = 1'b1;
                    bcnt = -1;
                end else if (bcnt > 0) begin
                    bcnt--;
                end
                wready = w_toggle ? !wready : 1'b1;
                #1;
                wl_hs = wvalid && wready && wlast;
                b_hs = bvalid && bready;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (resetn) begin
                if (arvalid && arready) begin
                    chk("ar_expected", 128'(exp_ar.size() != 0), 128'd1);
                    if (exp_ar.size() != 0) chk("araddr", 128'(araddr), 128'(exp_ar.pop_front()));
                end
                if (awvalid && awready) begin
                    chk("aw_expected", 128'(exp_aw.size() != 0), 128'd1);
                    if (exp_aw.size() != 0) chk("awaddr", 128'(awaddr), 128'(exp_aw.pop_front()));
                end
                if (wvalid && wready) begin
                    chk("w_expected", 128'(exp_w.size() != 0), 128'd1);
                    if (exp_w.size() != 0) chk("wlast_wdata", 128'({wlast, wdata}),
                                               128'(exp_w.pop_front()));
                end
                if (ret_valid) begin
                    ret_cyc = cyc;
                    chk("ret_expected", 128'(exp_ret.size() != 0), 128'd1);
                    if (exp_ret.size() != 0) chk("ret_data", ret_data, exp_ret.pop_front());
                end
                if (wr_valid) begin
                    wdone_cyc = cyc;
                    chk("wr_valid_expected", 128'(exp_wdone.size() != 0), 128'd1);
                    if (exp_wdone.size() != 0) exp_wdone.delete(0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        int a;
        int n;
        resetn = 1'b0;
        rd_req = 1'b0;
        rd_addr = 32'h0;
        wr_req = 1'b0;
        wr_addr = 32'h0;
        wr_data = 128'h0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("idle_rd_rdy", 128'(rd_rdy), 128'd1);
        chk("idle_wr_rdy", 128'(wr_rdy), 128'd1);

        // Refill with always-ready slave: line assembly and minimum latency.
        rd_issue(32'h1FC0_0014, 32'hA0, 128'h000000A3_000000A2_000000A1_000000A0, w, a);
        wait_idle("t1_drain");
        chk("t1_latency", 128'(ret_cyc - a), 128'd6);

        // Writeback with wready toggling; wr_data is scrambled right after accept.
        w_toggle = 1'b1;
        wr_issue(32'h8000_0040, 128'h00004444_00003333_00002222_00001111);
        wait_idle("t2_drain");
        w_toggle = 1'b0;

        // Same-line refill waits until the cycle after wr_valid.
        b_delay = 3;
        wr_issue(32'h0000_0100, 128'h13131313_12121212_11111111_10101010);
        rd_issue(32'h0000_0104, 32'hB0, 128'h000000B3_000000B2_000000B1_000000B0, w, a);
        chk("t3_raw_blocked", 128'(w > 0), 128'd1);
        chk("t3_raw_release", 128'(a), 128'(wdone_cyc + 1));
        wait_idle("t3_drain");

        // Different-line refill during a writeback is accepted at once.
        wr_issue(32'h0000_0100, 128'h23232323_22222222_21212121_20202020);
        rd_issue(32'h0000_0200, 32'hE0, 128'h000000E3_000000E2_000000E1_000000E0, w, a);
        chk("t3_no_conflict_wait", 128'(w), 128'd0);
        wait_idle("t3b_drain");
        b_delay = 0;

        // Same-cycle requests to different lines proceed concurrently.
        @(negedge clk);
        rd_base = 32'hF0;
        rd_req = 1'b1;
        rd_addr = 32'h0000_0300;
        wr_req = 1'b1;
        wr_addr = 32'h0000_0400;
        wr_data = 128'h44444444_43434343_42424242_41414141;
        #1;
        chk("t4_rd_rdy", 128'(rd_rdy), 128'd1);
        chk("t4_wr_rdy", 128'(wr_rdy), 128'd1);
        push_rd(32'h0000_0300, 128'h000000F3_000000F2_000000F1_000000F0);
        push_wr(32'h0000_0400, 128'h44444444_43434343_42424242_41414141);
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        #1;
        chk("t4_arvalid", 128'(arvalid), 128'd1);
        chk("t4_awvalid", 128'(awvalid), 128'd1);
        wait_idle("t4_drain");

        // Same-cycle requests to the same line: write wins, read waits.
        @(negedge clk);
        rd_req = 1'b1;
        rd_addr = 32'h0000_0508;
        wr_req = 1'b1;
        wr_addr = 32'h0000_0500;
        wr_data = 128'h55555555_54545454_53535353_52525252;
        #1;
        chk("t6_wr_rdy", 128'(wr_rdy), 128'd1);
        chk("t6_rd_held", 128'(rd_rdy), 128'd0);
        push_wr(32'h0000_0500, 128'h55555555_54545454_53535353_52525252);
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        rd_issue(32'h0000_0508, 32'h50, 128'h00000053_00000052_00000051_00000050, w, a);
        chk("t6_raw_release", 128'(a), 128'(wdone_cyc + 1));
        wait_idle("t6_drain");

        // Reset in the middle of a refill abandons it without a completion pulse.
        rd_issue(32'h0000_0600, 32'hC0, 128'h000000C3_000000C2_000000C1_000000C0, w, a);
        n = 0;
        while (!(rd_act && rd_beat == 2) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t5_reach_beat2", 128'(n < 50), 128'd1);
        @(negedge clk);
        resetn = 1'b0;
        exp_ret.delete();
        @(negedge clk);
        #1;
        check_zero("t5_reset");
        @(negedge clk);
        resetn = 1'b1;
        rd_issue(32'h0000_0700, 32'hD0, 128'h000000D3_000000D2_000000D1_000000D0, w, a);
        wait_idle("t5_drain");
        chk("t5_latency", 128'(ret_cyc - a), 128'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
